bus_cycle_seq: RTL and testbench

Parametrised external-memory bus-cycle sequencer: executes single or burst read/write transfers on the address-latched pad bus (ALE, nME, nOE, nWE, ENB). Configurable wait states, external stretch and burst length. Sits between the control unit and the pad ring. The control unit issues one request and waits for `Done` instead of hand-sequencing every pad strobe.

---
 rtl/bus_cycle_seq_pkg.sv | 10 +
 rtl/bus_cycle_seq_wait_timer.sv | 25 ++
 rtl/bus_cycle_seq.sv | 127 ++++++++++++
 tb/tb_bus_cycle_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_seq_pkg.sv
// Shared types for the pad-bus cycle sequencer: phase encoding and strobe idle levels.
package opcodes;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, END} bus_state_t;

  // Idle levels of the active-low (nME/nOE/nWE) and active-high (ALE/ENB) strobes.
  localparam logic STROBE_N_IDLE = 1'b1;
  localparam logic STROBE_IDLE   = 1'b0;

endpackage

// File: rtl/bus_cycle_seq_wait_timer.sv
// Loadable 4-bit down-counter that times the data phase; saturates at zero.
module wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_seq.sv
// Executes single or burst read/write transfers on the address-latched pad bus.
module bus_cycle_seq
  import opcodes::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned BL_W        = $clog2(MAX_BURST + 1)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Write,
  input  logic [BL_W-1:0]   BurstLen,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Ready,
  output logic              WAck,
  output logic [DATA_W-1:0] RData,
  output logic              RValid,
  output logic              Done,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWData,
  output logic              BusDataOe,
  input  logic [DATA_W-1:0] BusRData,
  input  logic              ExtWait,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              nWE,
  output logic              ENB
);

  localparam logic [3:0]      WaitLoad = 4'(WAIT_STATES);
  localparam logic [BL_W-1:0] MaxBeats = BL_W'(MAX_BURST);

  bus_state_t        state;
  logic              wr_q;
  logic [BL_W-1:0]   beats_q;
  logic [BL_W-1:0]   beats_init;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timer_zero;
  logic              last_beat;

  // Zero-length requests still run one beat; oversize requests are clamped.
  always_comb begin
    beats_init = BurstLen;
    if (BurstLen == '0) begin
      beats_init = BL_W'(1);
    end else if (BurstLen > MaxBeats) begin
      beats_init = MaxBeats;
    end
  end

  assign last_beat = (beats_q <= BL_W'(1));

  wait_timer u_wait_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (state == ADDR),
    .load_val (WaitLoad),
    .dec      (state == DATA),
    .zero     (timer_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      beats_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            state   <= ADDR;
            wr_q    <= Write;
            addr_q  <= Addr;
            beats_q <= beats_init;
          end
        end
        ADDR: begin
          state <= DATA;
          if (wr_q) wdata_q <= WData;
        end
        DATA: begin
          // ExtWait only stretches once the programmed wait states are spent.
          if (timer_zero && !ExtWait) begin
            state <= END;
            if (!wr_q) rdata_q <= BusRData;
          end
        end
        END: begin
          if (!last_beat) begin
            beats_q <= beats_q - BL_W'(1);
            addr_q  <= addr_q + ADDR_W'(1);
            state   <= ADDR;
          end else begin
            beats_q <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Ready     = (state == IDLE);
  assign WAck      = (state == ADDR) && wr_q;
  assign RValid    = (state == END) && !wr_q;
  assign Done      = (state == END) && last_beat;
  assign RData     = rdata_q;
  assign BusAddr   = addr_q;
  assign BusWData  = wdata_q;
  assign BusDataOe = wr_q && ((state == DATA) || (state == END));
  assign ALE       = (state == ADDR) ? ~STROBE_IDLE : STROBE_IDLE;
  assign ENB       = ((state == DATA) && !wr_q) ? ~STROBE_IDLE : STROBE_IDLE;
  assign nME       = (state == IDLE) ? STROBE_N_IDLE : ~STROBE_N_IDLE;
  assign nOE       = ((state == DATA) && !wr_q) ? ~STROBE_N_IDLE : STROBE_N_IDLE;
  assign nWE       = ((state == DATA) && wr_q) ? ~STROBE_N_IDLE : STROBE_N_IDLE;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Randomised scoreboard bench for bus_cycle_seq with a transaction-level reference model.
module tb_bus_cycle_seq;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WS  = 2;
  localparam int MB  = 4;
  localparam int BLW = $clog2(MB + 1);

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Req = 1'b0;
  logic           Write = 1'b0;
  logic [BLW-1:0] BurstLen = '0;
  logic [AW-1:0]  Addr = '0;
  logic [DW-1:0]  WData = '0;
  logic           ExtWait = 1'b0;
  logic [DW-1:0]  BusRData;
  logic           Ready, WAck, RValid, Done, BusDataOe, ALE, nME, nOE, nWE, ENB;
  logic [DW-1:0]  RData, BusWData;
  logic [AW-1:0]  BusAddr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] exp_addr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wd[$];
  logic [15:0] feed_wd[$];
  logic [15:0] dir_words[$];
  int          exp_dlen[$];
  int          exp_done[$];
  int          ext_plan[$];

  bus_cycle_seq #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_STATES (WS),
    .MAX_BURST   (MB),
    .BL_W        (BLW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .Write     (Write),
    .BurstLen  (BurstLen),
    .Addr      (Addr),
    .WData     (WData),
    .Ready     (Ready),
    .WAck      (WAck),
    .RData     (RData),
    .RValid    (RValid),
    .Done      (Done),
    .BusAddr   (BusAddr),
    .BusWData  (BusWData),
    .BusDataOe (BusDataOe),
    .BusRData  (BusRData),
    .ExtWait   (ExtWait),
    .ALE       (ALE),
    .nME       (nME),
    .nOE       (nOE),
    .nWE       (nWE),
    .ENB       (ENB)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory contents as seen on the pads: a fixed scramble of the address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    logic [15:0] k;
    k = 16'h9E37;
    return (a * k) ^ 16'h5A5A;
  endfunction

  assign BusRData = mem_f(BusAddr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Pad-side responder: supplies write words and ExtWait according to the per-beat plan.
  initial begin : responder
    int idx;
    int cur_ext;
    idx = 0;
    cur_ext = 0;
    forever begin
      @(negedge Clock);
      if (ALE) begin
        idx = 0;
        cur_ext = (ext_plan.size() > 0) ? ext_plan.pop_front() : 0;
      end
      if (WAck) WData = (feed_wd.size() > 0) ? feed_wd.pop_front() : 16'hDEAD;
      if (!nOE || !nWE) begin
        if (idx < WS) ExtWait = 1'($urandom_range(0, 1));
        else ExtWait = ((idx - WS) < cur_ext);
        idx++;
      end else begin
        ExtWait = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an observable event.
  initial begin : monitor
    int   dcnt;
    bit   wchk;
    bit   prev_data;
    dcnt = 0;
    wchk = 1'b0;
    prev_data = 1'b0;
    forever begin
      @(negedge Clock);
      if (ALE) begin
        if (exp_addr.size() == 0) flag("unexpected_ale");
        else chk("bus_addr", 32'(BusAddr), 32'(exp_addr.pop_front()));
        chk("ale_nme", 32'(nME), 32'd0);
        dcnt = 0;
        wchk = 1'b0;
      end
      if (!nOE || !nWE) begin
        dcnt++;
        if (!nOE) chk("read_enb", 32'(ENB), 32'd1);
        if (!nWE && !wchk) begin
          wchk = 1'b1;
          chk("write_oe", 32'(BusDataOe), 32'd1);
          if (exp_wd.size() == 0) flag("unexpected_write");
          else chk("bus_wdata", 32'(BusWData), 32'(exp_wd.pop_front()));
        end
      end
      if (prev_data && nOE && nWE && !nME) begin
        if (exp_dlen.size() == 0) flag("unexpected_end");
        else chk("data_len", 32'(dcnt), 32'(exp_dlen.pop_front()));
      end
      prev_data = !nOE || !nWE;
      if (RValid) begin
        if (exp_rd.size() == 0) flag("unexpected_rvalid");
        else chk("rdata", 32'(RData), 32'(exp_rd.pop_front()));
      end
      if (Done) begin
        if (exp_done.size() == 0) flag("unexpected_done");
        else chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!Ready && k < 300) begin
      @(negedge Clock);
      k++;
    end
    if (!Ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: Ready still 0 after %0d cycles", k);
    end
  endtask

  // Reference model: expands one request into its beats, pad addresses, data and timing.
  task automatic issue(input bit wr, input int bl, input logic [15:0] a, input int ext,
                       input bit noise);
    int n;
    int total;
    int e;
    logic [15:0] ba;
    logic [15:0] w;
    wait_ready();
    n = (bl == 0) ? 1 : ((bl > MB) ? MB : bl);
    total = 0;
    for (int b = 0; b < n; b++) begin
      ba = a + 16'(b);
      exp_addr.push_back(ba);
      if (wr) begin
        w = (dir_words.size() > 0) ? dir_words.pop_front() : 16'($urandom);
        feed_wd.push_back(w);
        exp_wd.push_back(w);
      end else begin
        exp_rd.push_back(mem_f(ba));
      end
      e = (ext < 0) ? int'($urandom_range(0, 3)) : ext;
      ext_plan.push_back(e);
      exp_dlen.push_back(WS + 1 + e);
      total += 3 + WS + e;
    end
    exp_done.push_back(cyc + total);
    Req = 1'b1;
    Write = wr;
    BurstLen = BLW'(bl);
    Addr = a;
    @(negedge Clock);
    Req = 1'b0;
    Write = 1'($urandom);
    Addr = 16'($urandom);
    if (noise) begin
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      if (!Ready) begin
        Req = 1'b1;
        Write = 1'($urandom);
        BurstLen = BLW'($urandom_range(0, 7));
        Addr = 16'($urandom);
        @(negedge Clock);
        Req = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_done.size() > 0 && k < 500) begin
      @(negedge Clock);
      k++;
    end
    if (exp_done.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d requests never completed", exp_done.size());
    end
    @(negedge Clock);
  endtask

  initial begin : stimulus
    int k;
    repeat (3) @(negedge Clock);
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_nme", 32'(nME), 32'd1);
    chk("rst_noe", 32'(nOE), 32'd1);
    chk("rst_nwe", 32'(nWE), 32'd1);
    chk("rst_ale", 32'(ALE), 32'd0);
    chk("rst_enb", 32'(ENB), 32'd0);
    chk("rst_oe", 32'(BusDataOe), 32'd0);
    chk("rst_addr", 32'(BusAddr), 32'd0);
    chk("rst_wdata", 32'(BusWData), 32'd0);
    chk("rst_rdata", 32'(RData), 32'd0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    chk("idle_ready", 32'(Ready), 32'd1);
    chk("idle_nme", 32'(nME), 32'd1);

    issue(1'b0, 1, 16'h0040, 0, 1'b0);
    drain();
    dir_words.push_back(16'h0011);
    dir_words.push_back(16'h0022);
    dir_words.push_back(16'h0033);
    issue(1'b1, 3, 16'h1000, 0, 1'b1);
    drain();
    issue(1'b0, 1, 16'h2222, 3, 1'b0);
    drain();
    issue(1'b0, 7, 16'hFFFF, -1, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom), -1, 1'b1);
    end
    drain();

    // Reset during beat 2 of a read burst, with a Req raised while busy.
    issue(1'b0, 4, 16'h3000, 0, 1'b0);
    k = 0;
    while (!(ALE && BusAddr == 16'h3001) && k < 100) begin
      @(negedge Clock);
      k++;
    end
    chk("second_beat_seen", 32'(BusAddr), 32'h3001);
    Req = 1'b1;
    Write = 1'b1;
    Addr = 16'h7777;
    BurstLen = BLW'(2);
    @(negedge Clock);
    Req = 1'b0;
    Reset = 1'b1;
    exp_addr.delete();
    exp_rd.delete();
    exp_wd.delete();
    feed_wd.delete();
    exp_dlen.delete();
    exp_done.delete();
    ext_plan.delete();
    @(negedge Clock);
    chk("midrst_ready", 32'(Ready), 32'd1);
    chk("midrst_nme", 32'(nME), 32'd1);
    chk("midrst_noe", 32'(nOE), 32'd1);
    chk("midrst_ale", 32'(ALE), 32'd0);
    chk("midrst_addr", 32'(BusAddr), 32'd0);
    chk("midrst_rdata", 32'(RData), 32'd0);
    Reset = 1'b0;
    repeat (15) @(negedge Clock);
    chk("post_rst_ready", 32'(Ready), 32'd1);

    issue(1'b1, 2, 16'h0100, -1, 1'b0);
    drain();
    issue(1'b0, 0, 16'h0200, -1, 1'b0);
    drain();
    chk("left_addr", 32'(exp_addr.size()), 32'd0);
    chk("left_rdata", 32'(exp_rd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
